// File: rtl/store_narrower.sv
// Store narrowing unit: lane-replicates SB/SH/SW data, builds byte strobes, issues one aligned memory write.
// Latency: request accepted in cycle T appears on the memory port at T+1; DONE pulses the cycle after MEM_READY.
// Backpressure: REQ_READY is low while a write waits for MEM_READY; the write is held stable until accepted.
//
// Ports:
//   i_clk, i_rst                      clock, synchronous active-high reset
//   i_req_valid / o_req_ready         store request handshake (ready only in IDLE)
//   i_req_addr, i_req_data, i_req_size  byte address, rs2 value, 00 byte / 01 half / 10,11 word
//   o_mem_valid / i_mem_ready         memory write handshake
//   o_mem_addr, o_mem_wdata, o_mem_strb  word-aligned address, replicated data, byte enables
//   o_done, o_misalign                one-cycle completion / rejection pulses
//
// Optional feature macro: STORE_MISALIGN_TRAP_EN. When defined, misaligned halves and words are
// rejected with an o_misalign pulse; otherwise they are force-aligned and o_misalign is tied low.

module store_narrower #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [31:0]           i_req_data,
  input  logic [1:0]            i_req_size,
  output logic                  o_mem_valid,
  input  logic                  i_mem_ready,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [31:0]           o_mem_wdata,
  output logic [3:0]            o_mem_strb,
  output logic                  o_done,
  output logic                  o_misalign
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [31:0]           r_mem_wdata;
  logic [3:0]            r_mem_strb;
  logic                  r_done;

  logic [1:0]            w_offset;
  logic [31:0]           w_wdata;
  logic [3:0]            w_strb;
  logic                  w_trap;
  logic                  w_accept;
  logic                  w_start;

  assign w_offset    = i_req_addr[1:0];
  assign o_req_ready = (r_state == S_IDLE);
  assign o_mem_valid = (r_state == S_SEND);
  assign w_accept    = i_req_valid && o_req_ready;
  // A trapped request is consumed but never reaches the memory port.
  assign w_start     = w_accept && !w_trap;

  // Lane replication and strobe generation; the reserved size behaves as a word.
  always_comb begin
    w_wdata = i_req_data;
    w_strb  = 4'b1111;
    case (i_req_size)
      2'b00: begin
        w_wdata = {4{i_req_data[7:0]}};
        case (w_offset)
          2'b00:   w_strb = 4'b0001;
          2'b01:   w_strb = 4'b0010;
          2'b10:   w_strb = 4'b0100;
          default: w_strb = 4'b1000;
        endcase
      end
      2'b01: begin
        w_wdata = {2{i_req_data[15:0]}};
        w_strb  = w_offset[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        w_wdata = i_req_data;
        w_strb  = 4'b1111;
      end
    endcase
  end

`ifdef STORE_MISALIGN_TRAP_EN
  logic r_misalign;

  always_comb begin
    w_trap = 1'b0;
    if (i_req_size == 2'b01)
      w_trap = w_offset[0];
    else if (i_req_size[1])
      w_trap = (w_offset != 2'b00);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_misalign <= 1'b0;
    else
      r_misalign <= w_accept && w_trap;
  end

  assign o_misalign = r_misalign;
`else
  assign w_trap     = 1'b0;
  assign o_misalign = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_SEND;
      S_SEND:  if (i_mem_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_strb  <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= (r_state == S_SEND) && i_mem_ready;
      // Payload only loads at acceptance, so it stays frozen through a stall.
      if (w_start) begin
        r_mem_addr  <= {i_req_addr[ADDR_WIDTH-1:2], 2'b00};
        r_mem_wdata <= w_wdata;
        r_mem_strb  <= w_strb;
      end
    end
  end

  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_strb  = r_mem_strb;
  assign o_done      = r_done;

endmodule
